// File: rtl/alu_exec_stage_pkg.sv
// Shared constants and types for the Y86-64 execute stage.
package alu_exec_stage_pkg;

    localparam int unsigned DATA_WID = 64;

    // ALU function select as driven by the decode-side helper logic
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alufun_t;

    // Condition-code bit positions
    localparam int unsigned CC_ZF = 0;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 2;

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] CC_RESET = 4'b0001;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: operand/control inputs plus the E/M latch and CC outputs.
interface alu_exec_stage_if #(
    parameter int unsigned DATA_WID = 64
);
    logic                in_valid;
    logic                stall;
    logic                bubble;
    logic                suppress_cc;
    logic [DATA_WID-1:0] aluA;
    logic [DATA_WID-1:0] aluB;
    logic [1:0]          alufun;
    logic                set_cc;
    logic [3:0]          dstE_in;
    logic                m_valid;
    logic [DATA_WID-1:0] m_valE;
    logic [3:0]          m_dstE;
    logic [3:0]          cc;

    // Upstream pipeline control / operand source
    modport master (
        output in_valid, stall, bubble, suppress_cc,
        output aluA, aluB, alufun, set_cc, dstE_in,
        input  m_valid, m_valE, m_dstE, cc
    );

    // Execute stage itself
    modport slave (
        input  in_valid, stall, bubble, suppress_cc,
        input  aluA, aluB, alufun, set_cc, dstE_in,
        output m_valid, m_valE, m_dstE, cc
    );
endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational Y86-64 ALU: result and ZF/SF/OF for Add/Sub/And/Xor.
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_WID = alu_exec_stage_pkg::DATA_WID
) (
    input  logic [DATA_WID-1:0] i_alu_a,
    input  logic [DATA_WID-1:0] i_alu_b,
    input  logic [1:0]          i_alufun,
    output logic [DATA_WID-1:0] o_r,
    output logic                o_zf,
    output logic                o_sf,
    output logic                o_of
);

    logic [DATA_WID-1:0] w_r;
    logic                w_of;
    logic                w_a_msb;
    logic                w_b_msb;

    assign w_a_msb = i_alu_a[DATA_WID-1];
    assign w_b_msb = i_alu_b[DATA_WID-1];

    // Result and signed-overflow per function; B is the left-hand operand
    always_comb begin
        w_r  = '0;
        w_of = 1'b0;
        case (alufun_t'(i_alufun))
            ALU_ADD: begin
                w_r  = i_alu_b + i_alu_a;
                w_of = (w_a_msb == w_b_msb) && (w_r[DATA_WID-1] != w_a_msb);
            end
            ALU_SUB: begin
                w_r  = i_alu_b - i_alu_a;
                w_of = (w_a_msb != w_b_msb) && (w_r[DATA_WID-1] != w_b_msb);
            end
            ALU_AND: w_r = i_alu_b & i_alu_a;
            ALU_XOR: w_r = i_alu_b ^ i_alu_a;
            default: w_r = '0;
        endcase
    end

    assign o_r  = w_r;
    assign o_zf = (w_r == '0);
    assign o_sf = w_r[DATA_WID-1];
    assign o_of = w_of;

endmodule

// File: rtl/alu_exec_stage.sv
// Y86-64 execute stage: ALU, E/M pipeline latch and CC register writer.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned DATA_WID = alu_exec_stage_pkg::DATA_WID,
    parameter logic [3:0]  RNONE    = alu_exec_stage_pkg::RNONE,
    parameter logic [3:0]  CC_RESET = alu_exec_stage_pkg::CC_RESET
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_stage_if.slave  bus
);

    logic [DATA_WID-1:0] w_r;
    logic                w_zf;
    logic                w_sf;
    logic                w_of;
    logic [3:0]          w_cc_new;
    logic                w_cc_we;

    logic                r_m_valid;
    logic [DATA_WID-1:0] r_m_valE;
    logic [3:0]          r_m_dstE;
    logic [3:0]          r_cc;

    alu_core #(
        .DATA_WID (DATA_WID)
    ) u_alu_core (
        .i_alu_a  (bus.aluA),
        .i_alu_b  (bus.aluB),
        .i_alufun (bus.alufun),
        .o_r      (w_r),
        .o_zf     (w_zf),
        .o_sf     (w_sf),
        .o_of     (w_of)
    );

    // Pack fresh flags into CC layout; bit 3 is always written as zero
    always_comb begin
        w_cc_new        = '0;
        w_cc_new[CC_ZF] = w_zf;
        w_cc_new[CC_SF] = w_sf;
        w_cc_new[CC_OF] = w_of;
    end

    assign w_cc_we = bus.in_valid & bus.set_cc & ~bus.suppress_cc
                   & ~bus.stall & ~bus.bubble;

    // E/M latch: reset > stall (hold) > bubble / no instruction > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_valE  <= '0;
            r_m_dstE  <= RNONE;
        end else if (bus.stall) begin
            r_m_valid <= r_m_valid;
            r_m_valE  <= r_m_valE;
            r_m_dstE  <= r_m_dstE;
        end else if (bus.bubble || !bus.in_valid) begin
            r_m_valid <= 1'b0;
            r_m_valE  <= '0;
            r_m_dstE  <= RNONE;
        end else begin
            r_m_valid <= 1'b1;
            r_m_valE  <= w_r;
            r_m_dstE  <= bus.dstE_in;
        end
    end

    // CC register: updated only by a live, unsuppressed set_cc instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_cc_we) begin
            r_cc <= w_cc_new;
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_valE  = r_m_valE;
    assign bus.m_dstE  = r_m_dstE;
    assign bus.cc      = r_cc;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed plan plus random traffic.
module tb_alu_exec_stage;

    localparam int unsigned W = 64;

    typedef struct {
        logic         valid;
        logic [W-1:0] valE;
        logic [3:0]   dstE;
        logic [3:0]   cc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_exec_stage_if #(.DATA_WID(W)) bus ();

    alu_exec_stage #(
        .DATA_WID (W),
        .RNONE    (4'hF),
        .CC_RESET (4'b0001)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        sb_q[$];

    // Bench-side model state of the E/M latch and CC
    logic         m_valid_q = 1'b0;
    logic [W-1:0] m_valE_q  = '0;
    logic [3:0]   m_dstE_q  = 4'hF;
    logic [3:0]   cc_q      = 4'b0001;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU using signed-range reasoning for overflow
    task automatic ref_alu(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [3:0] flags);
        logic signed [W-1:0] sa, sb, sr;
        logic ovf;
        sa = a;
        sb = b;
        ovf = 1'b0;
        case (fun)
            2'b00: r = a + b;
            2'b01: r = b - a;
            2'b10: r = a & b;
            default: r = a ^ b;
        endcase
        sr = r;
        if (fun == 2'b00)
            ovf = (sa > 0 && sb > 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
        else if (fun == 2'b01)
            ovf = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
        flags = {1'b0, ovf, sr < 0, r == 0};
    endtask

    // Drive one cycle of stimulus, predict the next state, compare after the edge
    task automatic step(input logic rs, input logic v, input logic st, input logic bu,
                        input logic sup, input logic [1:0] fun, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sc, input logic [3:0] dst);
        logic [W-1:0] r;
        logic [3:0]   fl;
        exp_t         e, got_e;
        rst             = rs;
        bus.in_valid    = v;
        bus.stall       = st;
        bus.bubble      = bu;
        bus.suppress_cc = sup;
        bus.alufun      = fun;
        bus.aluA        = a;
        bus.aluB        = b;
        bus.set_cc      = sc;
        bus.dstE_in     = dst;
        ref_alu(fun, a, b, r, fl);
        if (rs) begin
            m_valid_q = 1'b0; m_valE_q = '0; m_dstE_q = 4'hF; cc_q = 4'b0001;
        end else if (!st) begin
            if (bu || !v) begin
                m_valid_q = 1'b0; m_valE_q = '0; m_dstE_q = 4'hF;
            end else begin
                m_valid_q = 1'b1; m_valE_q = r; m_dstE_q = dst;
                if (sc && !sup) cc_q = fl;
            end
        end
        e.valid = m_valid_q; e.valE = m_valE_q; e.dstE = m_dstE_q; e.cc = cc_q;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
        end else begin
            got_e = sb_q.pop_front();
            check("m_valid", {63'd0, bus.m_valid}, {63'd0, got_e.valid});
            check("m_valE",  bus.m_valE, got_e.valE);
            check("m_dstE",  {60'd0, bus.m_dstE}, {60'd0, got_e.dstE});
            check("cc",      {60'd0, bus.cc}, {60'd0, got_e.cc});
        end
    endtask

    initial begin
        // 1. Reset held two cycles
        step(1, 0, 0, 0, 0, 2'b00, '0, '0, 0, 4'h0);
        step(1, 0, 0, 0, 0, 2'b00, '0, '0, 0, 4'h0);
        check("rst_valE_const", bus.m_valE, 64'd0);
        check("rst_cc_const", {60'd0, bus.cc}, 64'd1);
        check("rst_dstE_const", {60'd0, bus.m_dstE}, 64'hF);

        // 2. Add overflow
        step(0, 1, 0, 0, 0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1, 4'd3);
        check("addov_valE_const", bus.m_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("addov_cc_const", {60'd0, bus.cc}, 64'b0110);

        // 3. Sub to zero, then And without set_cc
        step(0, 1, 0, 0, 0, 2'b01, 64'd5, 64'd5, 1, 4'd1);
        check("subz_cc_const", {60'd0, bus.cc}, 64'b0001);
        step(0, 1, 0, 0, 0, 2'b10, 64'd6, 64'd3, 0, 4'd2);
        check("and_valE_const", bus.m_valE, 64'd2);

        // 4. Xor then stall x3, stall+bubble, bubble alone
        step(0, 1, 0, 0, 0, 2'b11, 64'd1, 64'd3, 1, 4'd4);
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 0, 2'b00, 64'd100 + 64'(i), 64'd7, 1, 4'd9);
        check("stall_valE_const", bus.m_valE, 64'd2);
        step(0, 1, 1, 1, 0, 2'b01, 64'd9, 64'd1, 1, 4'd8);
        step(0, 1, 0, 1, 0, 2'b01, 64'd9, 64'd1, 1, 4'd8);
        check("bubble_dstE_const", {60'd0, bus.m_dstE}, 64'hF);

        // 5. Suppressed CC write, then the same op unsuppressed
        step(0, 1, 0, 0, 1, 2'b01, 64'd1, 64'd0, 1, 4'd5);
        check("sup_valE_const", bus.m_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 1, 0, 0, 0, 2'b01, 64'd1, 64'd0, 1, 4'd5);
        check("unsup_cc_const", {60'd0, bus.cc}, 64'b0010);

        // set_cc Sub with in_valid=0 must not touch cc
        step(0, 0, 0, 0, 0, 2'b01, 64'd3, 64'd3, 1, 4'd6);

        // 6. Reset on the same edge as a valid set_cc Add
        step(1, 1, 0, 0, 0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 4'd7);
        check("midrst_cc_const", {60'd0, bus.cc}, 64'b0001);

        // Random traffic including sign-boundary operands
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = {1'b0, {63{1'b1}}};
            if ($urandom_range(0, 3) == 0) b = {1'b1, 63'd0};
            if ($urandom_range(0, 5) == 0) b = a;
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), a, b,
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 14)));
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
